// File: rtl/simon_key_schedule.sv
// Iterative Simon64/128 key expansion: loads a 128-bit master key, then streams
// round keys k[0..ROUNDS-1] over a valid/ready handshake, one key per accepted cycle.
module simon_key_schedule #(
  parameter int          ROUNDS = 44,
  parameter logic [61:0] ZSEQ   = 62'b11011011101011000110010111100000010010001010011100110100001111
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [31:0]  rk,
  output logic [5:0]   rk_idx,
  output logic         rk_last
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);
  localparam logic [5:0] PRE_LAST = 6'(ROUNDS - 2);
  localparam logic [5:0] Z_LAST   = 6'd61;

  state_t      state;
  logic [31:0] w [4];
  logic [31:0] shift_in [4];
  logic [5:0]  zptr;
  logic [31:0] t;
  logic [31:0] knew;
  logic        zbit;

  // ZSEQ is written with z[0] as its leftmost (MSB) bit.
  assign zbit = ZSEQ[Z_LAST - zptr];
  assign t    = {w[3][2:0], w[3][31:3]} ^ w[1];
  assign knew = 32'hffff_fffc ^ {31'b0, zbit} ^ w[0] ^ t ^ {t[0], t[31:1]};
  assign rk   = w[0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_shift
      if (gi < 3) begin : g_mid
        assign shift_in[gi] = w[gi+1];
      end else begin : g_top
        assign shift_in[gi] = knew;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      rk_idx    <= 6'd0;
      zptr      <= 6'd0;
      for (int j = 0; j < 4; j++) w[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid) begin
            for (int j = 0; j < 4; j++) w[j] <= key_in[32*j +: 32];
            rk_idx    <= 6'd0;
            zptr      <= 6'd0;
            state     <= RUN;
            key_ready <= 1'b0;
            rk_valid  <= 1'b1;
            rk_last   <= 1'b0;
          end
        end
        RUN: begin
          if (rk_ready) begin
            for (int j = 0; j < 4; j++) w[j] <= shift_in[j];
            rk_idx  <= rk_idx + 6'd1;
            zptr    <= (zptr == Z_LAST) ? 6'd0 : zptr + 6'd1;
            rk_last <= (rk_idx == PRE_LAST);
            // Retiring the final key: drop back to IDLE so a new key can load.
            if (rk_idx == LAST_IDX) begin
              state     <= IDLE;
              key_ready <= 1'b1;
              rk_valid  <= 1'b0;
              rk_last   <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_schedule.sv
// Scoreboard bench for simon_key_schedule: stimulus queues expected round keys,
// a negedge monitor pops and compares on every rk handshake.
module tb_simon_key_schedule;
  localparam int          ROUNDS = 44;
  localparam logic [61:0] Z      = 62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [127:0] KEY1  = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] KEY2  = 128'h0f0e0d0c_5a5a5a5a_deadbeef_01234567;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [31:0]  rk;
  logic [5:0]   rk_idx;
  logic         rk_last;

  simon_key_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk),
    .rk_idx(rk_idx), .rk_last(rk_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] key;
    logic [5:0]  idx;
    logic        last;
    logic [7:0]  gap;   // required cycles since previous handshake, 0 = any
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          last_hs_cycle = -100;
  logic [31:0] model_k [64];
  logic [31:0] cap_k [64];
  logic [31:0] hand_k [5] = '{32'h03020100, 32'h0b0a0908, 32'h13121110, 32'h1b1a1918, 32'h70a011c3};
  logic        stall_pending = 1'b0;
  logic [31:0] stall_rk;
  logic [5:0]  stall_idx;
  logic        stall_last;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference Simon64/128 key expansion straight from the cipher definition.
  task automatic gen_model(input logic [127:0] k);
    logic [31:0] tt;
    for (int i = 0; i < 4; i++) model_k[i] = k[32*i +: 32];
    for (int i = 0; i < ROUNDS - 4; i++) begin
      tt = ror(model_k[i+3], 3) ^ model_k[i+1];
      tt = tt ^ ror(tt, 1);
      model_k[i+4] = ~model_k[i] ^ tt ^ 32'd3 ^ {31'b0, Z[61 - (i % 62)]};
    end
  endtask

  task automatic push_sched(input logic [127:0] k, input int gap0, input int gap_rest);
    exp_t x;
    gen_model(k);
    for (int i = 0; i < ROUNDS; i++) begin
      x.key  = (k == KEY1 && i < 5) ? hand_k[i] : model_k[i];
      x.idx  = 6'(i);
      x.last = (i == ROUNDS - 1);
      x.gap  = 8'((i == 0) ? gap0 : gap_rest);
      sb.push_back(x);
    end
  endtask

  task automatic wait_drain(input int limit, input bit random_ready);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      if (random_ready) rk_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d keys outstanding, expected 0", sb.size());
      sb.delete();
    end
    rk_ready = 1'b1;
  endtask

  task automatic wait_key_ready(input int limit);
    int n = 0;
    while (key_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (key_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL key_ready_timeout: key_ready=%b, expected 1", key_ready);
    end
  endtask

  // Monitor: compare every handshake against the scoreboard, and hold-check stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_pending) begin
        chk("stall_hold", {rk_valid, rk_last, rk_idx, rk}, {1'b1, stall_last, stall_idx, stall_rk});
      end
      stall_pending = 1'b0;
      if (rk_valid && !rk_ready) begin
        stall_pending = 1'b1;
        stall_rk      = rk;
        stall_idx     = rk_idx;
        stall_last    = rk_last;
      end
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key: got idx=%0d rk=%h, expected none", rk_idx, rk);
        end else begin
          e = sb.pop_front();
          $display("rk idx=%0d key=%h last=%b", rk_idx, rk, rk_last);
          chk("round_key", {25'b0, rk_last, rk_idx, rk}, {25'b0, e.last, e.idx, e.key});
          if (e.gap != 0) chk("hs_gap", 64'(cycle - last_hs_cycle), 64'(e.gap));
          cap_k[rk_idx] = rk;
        end
        last_hs_cycle = cycle;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y, tmp;

    // Reset state
    tick(); tick();
    chk("reset_state", {59'b0, key_ready, rk_valid, rk_last, 2'b0}, {59'b0, 1'b1, 1'b0, 1'b0, 2'b0});
    chk("reset_rk", {26'b0, rk_idx, rk}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Full schedule with rk_ready=1: no bubbles, 1-cycle load latency
    rk_ready = 1'b1;
    push_sched(KEY1, 0, 1);
    key_in = KEY1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("load_latency", {31'b0, rk_valid, rk}, {31'b0, 1'b1, 32'h03020100});
    wait_drain(100, 1'b0);
    chk("idle_after_last", {61'b0, key_ready, rk_valid, rk_last}, {61'b0, 3'b100});
    x = 32'h656b696c; y = 32'h20646e75;
    for (int i = 0; i < ROUNDS; i++) begin
      tmp = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ cap_k[i];
      y = tmp;
    end
    chk("ciphertext", {x, y}, 64'h44c8fc20_b9dfa07a);

    // Random backpressure
    tick();
    push_sched(KEY1, 0, 0);
    key_in = KEY1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_drain(2000, 1'b1);

    // Key offered during RUN waits for IDLE
    tick();
    push_sched(KEY1, 0, 1);
    key_in = KEY1; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int n = 0; n < 40 && rk_idx != 6'd10; n++) tick();
    chk("reach_idx10", 64'(rk_idx), 64'd10);
    key_in = KEY2; key_valid = 1'b1;
    push_sched(KEY2, 2, 1);
    wait_key_ready(100);
    tick();
    key_valid = 1'b0;
    chk("second_key_first", {31'b0, rk_valid, rk}, {31'b0, 1'b1, KEY2[31:0]});
    wait_drain(100, 1'b0);

    // Asynchronous reset mid-stream
    tick();
    push_sched(KEY2, 0, 0);
    key_in = KEY2; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (7) begin
      rk_ready = 1'($urandom_range(0, 1));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_ctl", {61'b0, key_ready, rk_valid, rk_last}, {61'b0, 3'b100});
    chk("midrun_reset_rk", {26'b0, rk_idx, rk}, 64'd0);
    sb.delete();
    stall_pending = 1'b0;
    rk_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back schedules: KEY1 then KEY2 with a single load cycle between
    push_sched(KEY1, 0, 1);
    push_sched(KEY2, 2, 1);
    key_in = KEY1; key_valid = 1'b1;
    tick();
    key_in = KEY2;
    wait_key_ready(100);
    tick();
    key_valid = 1'b0;
    wait_drain(200, 1'b0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_key_schedule.md
Name: simon_key_schedule

Overview:
- Iterative Simon64/128 key expansion; sits directly upstream of the combinational Simon round stage (64-bit block, 32-bit words, rotations 1/8/2).
- Accepts one 128-bit master key, then streams the 44 round keys k[0..43] in order, one per accepted handshake.
- The round-key output feeds the 32-bit key input of the round stage. Rotation and constant usage here are fixed to the Simon64/128 definition.

Parameters:
- ROUNDS, 44, number of round keys emitted per key load; legal range 4..64.
- ZSEQ, 62'b11011011101011000110010111100000010010001010011100110100001111, Simon constant sequence z3 (leftmost bit is z[0]).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  master key present on key_in.
- key_ready  out  1  block can accept a key.
- key_in  in  128  master key; key_in[31:0]=k[0], [63:32]=k[1], [95:64]=k[2], [127:96]=k[3].
- rk_valid  out  1  round key present on rk.
- rk_ready  in  1  downstream consumes rk this cycle.
- rk  out  32  current round key k[i].
- rk_idx  out  6  index i of rk.
- rk_last  out  1  high with rk_valid when i==ROUNDS-1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, key_ready=1, rk_valid=0, rk=0, rk_idx=0, rk_last=0, window registers=0, z pointer=0.
- Two states, IDLE and RUN.
- In IDLE, key_ready=1 and rk_valid=0.
  - key_valid&key_ready loads the 4-word window w0..w3 = k[0..3], clears rk_idx and the z pointer, and enters RUN.
  - rk_valid rises on the next cycle with rk=k[0]. Load-to-first-key latency is 1 cycle.
- In RUN, key_ready=0, rk_valid=1, rk=w0, rk_idx=i.
  - A handshake (rk_valid&rk_ready) advances i by 1 and shifts the window: w0<=w1, w1<=w2, w2<=w3, w3<=knew.
  - knew = ~w0 ^ 3 ^ z[i mod 62] ^ t ^ ROR(t,1), where t = ROR(w3,3) ^ w1.
  - Equivalently knew = 32'hFFFFFFFC ^ {31'b0,z[i mod 62]} ^ w0 ^ t ^ ROR(t,1).
  - i here is the index of the key being retired (w0). This yields k[i+4].
- Backpressure: when rk_ready=0, rk, rk_idx, rk_last and the window hold stable; no key is skipped or repeated.
- Handshake on rk_last (i==ROUNDS-1) returns to IDLE. rk_valid=0 and key_ready=1 on the next cycle.
- No bubble between keys: with rk_ready held high, k[0..ROUNDS-1] appear on ROUNDS consecutive cycles.
- z pointer wraps 61->0. This is unreachable at default ROUNDS and required for ROUNDS>62 only if the range is later extended.
- key_valid in RUN is ignored. The new key waits until key_ready=1, and the pending key is not lost if the source holds it.
- No combinational path from rk_ready or key_valid to any output.
- Reset asserted mid-stream clears to the reset values immediately. The partial schedule is discarded; a fresh key load is required.

Test Plan:
- Reset check: assert rst_n=0 mid-RUN at arbitrary phase -> same cycle rk_valid=0, key_ready=1, rk_idx=0, rk=0.
- Load and first keys: key_in=128'h1b1a1918_13121110_0b0a0908_03020100, rk_ready=1.
  - rk_valid rises 1 cycle after load.
  - rk sequence starts 03020100, 0b0a0908, 13121110, 1b1a1918, 70a011c3.
  - rk_idx runs 0,1,2,3,4.
- Full schedule: same key, rk_ready=1.
  - Exactly 44 consecutive valid cycles, matching a software Simon64/128 model.
  - rk_last only at idx 43; key_ready=1 the cycle after.
  - Chaining the 44 keys through the round stage on pt 64'h656b696c_20646e75 (x[63:32]=656b696c) gives ct 64'h44c8fc20_b9dfa07a.
- Backpressure: random rk_ready (about 50%) -> identical key sequence to the unstalled run; outputs stable during every stall cycle.
- Key during RUN: hold key_valid=1 with a second key from idx 10 -> no effect until IDLE; the second key loads the cycle key_ready=1 and its k[0] appears the next cycle.
- Back-to-back schedules: two keys issued consecutively with rk_ready=1 -> 44 keys, then 1 idle cycle (load), then 44 keys for the second key, each matching the model.
